// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor: Diff = A - B - Bin, four bits per clock, one nibble per cycle through a 4-bit borrow-lookahead slice.
// Optional signed overflow flag is built in when NIBBLE_SUB_OVF_EN is defined; otherwise ovf is tied to 0.
module nibble_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             ovf
);
    localparam int NIB = WIDTH / 4;
    localparam int KW  = NIB > 1 ? $clog2(NIB) : 1;
    typedef enum logic {IDLE, RUN} state_t;
    state_t           state;
    logic [WIDTH-1:0] a_r, b_r, work, nxt;
    logic             borrow;
    logic [KW-1:0]    k;
    logic [3:0]       an, bn, g, p, sum;
    logic [4:0]       c;
    logic             fin;
    assign an  = a_r[{k, 2'b00} +: 4];
    assign bn  = b_r[{k, 2'b00} +: 4];
    assign fin = (state == RUN) && (k == KW'(NIB - 1));
    // subtraction as A + ~B + ~borrow, carries in full two-level lookahead form
    always_comb begin
        g    = an & ~bn;
        p    = an ^ ~bn;
        c[0] = ~borrow;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        sum  = p ^ c[3:0];
        nxt  = work;
        nxt[{k, 2'b00} +: 4] = sum;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_r    <= '0;
            b_r    <= '0;
            work   <= '0;
            borrow <= 1'b0;
            k      <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            Diff   <= '0;
            Bout   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    a_r    <= A;
                    b_r    <= B;
                    borrow <= Bin;
                    k      <= '0;
                    busy   <= 1'b1;
                    state  <= RUN;
                end
            end else begin
                work   <= nxt;
                borrow <= ~c[4];
                k      <= k + 1'b1;
                if (fin) begin
                    Diff  <= nxt;
                    Bout  <= ~c[4];
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
            end
        end
    end
`ifdef NIBBLE_SUB_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf <= 1'b0;
        else if (fin) ovf <= c[3] ^ c[4];
    end
`else
    assign ovf = 1'b0;
`endif
endmodule

// File: doc/nibble_serial_subtractor.md
# nibble_serial_subtractor

Multi-cycle WIDTH-bit subtractor computing Diff = A − B − Bin, four bits per clock, through a single 4-bit borrow-lookahead slice. It is the subtraction counterpart of the team's 4-bit carry-lookahead adder. It is used where a full-width lookahead subtractor costs too much area and a latency of WIDTH/4 cycles is acceptable. Operands are accepted with a start/busy/done handshake, and the result is held in a register until the next operation completes.

## Interface
- WIDTH, 16: operand width in bits; must be a multiple of 4 and ≥ 4. NIB = WIDTH/4.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled on rising edge of clk
- A  in  WIDTH  minuend
- B  in  WIDTH  subtrahend
- Bin  in  1  borrow in
- busy  out  1  operation in progress
- done  out  1  single-cycle completion pulse
- Diff  out  WIDTH  result register
- Bout  out  1  borrow out of the MSB
- ovf  out  1  signed two's-complement overflow (see Configuration)

## Operation
- States: IDLE and RUN.
- IDLE, start=1:
  - Latch A, B and Bin into internal registers.
  - Clear the nibble index k to 0.
  - Go to RUN and set busy=1.
- IDLE, start=0: hold.
- RUN processes one nibble per cycle, LSB nibble first, using the latched A_k and B_k:
  - c0 = ~borrow, where borrow is the latched Bin for k=0 and the previous nibble's borrow afterwards.
  - Form the lookahead terms on A_k and ~B_k: G = A_k & ~B_k, P = A_k ^ ~B_k.
  - Carries c1..c4 use full lookahead equations, with no ripple.
  - Sum nibble = P ^ {c3,c2,c1,c0}.
  - Nibble borrow out = ~c4.
  - Write the sum nibble into the working shift register and increment k.
- On the edge that processes nibble NIB−1:
  - Copy the working register, including the final nibble, into Diff.
  - Bout = ~c4 of that nibble.
  - ovf = c3 ^ c4 of that nibble, which are the carries into and out of the MSB.
  - Pulse done=1 and clear busy=0.
  - Return to IDLE.
- start while busy=1 is ignored; latched operands are unaffected.
- A, B and Bin may change freely after the accepting edge.
- Diff, Bout and ovf change only on completion edges and on reset. Otherwise they hold their values, including during RUN.
- Arithmetic is modulo 2^WIDTH.
  - Bout=1 exactly when A < B + Bin, unsigned.
  - ovf=1 exactly when the signed result is outside [−2^(WIDTH−1), 2^(WIDTH−1)−1].

## Timing
- Reset values: busy=0, done=0, Diff=0, Bout=0, ovf=0; state IDLE; internal registers zero.
- Reset is asynchronous assert, released synchronously to clk by the system.
- Accepting edge T0 (start=1 in IDLE): busy=1 after T0.
- Edges T1..TNIB process nibbles 0..NIB−1.
- After TNIB:
  - done=1 for exactly one cycle.
  - busy=0.
  - Diff, Bout and ovf are valid.
- Latency is NIB cycles from the accepting edge to done. Default WIDTH=16 gives 4 cycles.
- Back-to-back: during the done cycle busy=0, so start=1 is accepted on the next edge. Throughput is one result per NIB+1 cycles.
- WIDTH=4: single nibble; done follows T0 by one cycle.
- rst_n asserted mid-RUN:
  - The operation is aborted and no done is issued.
  - All outputs return to reset values immediately.
  - The operation is not resumed after release.

## Configuration
- Macro: NIBBLE_SUB_OVF_EN.
- Defined: signed overflow detection is built in; ovf is registered as specified above.
- Undefined: the overflow logic and register are omitted and ovf is tied to constant 0. Port list, latency and all other behaviour are identical.

## Test plan
- WIDTH=16, A=0x1234, B=0x0234, Bin=0, start pulse: done exactly 4 cycles after the accepting edge. Diff=0x1000, Bout=0, ovf=0.
- A=0x0000, B=0x0001, Bin=0: Diff=0xFFFF, Bout=1, ovf=0. A=0x0005, B=0x0005, Bin=1: Diff=0xFFFF, Bout=1, ovf=0. Both check borrow propagation across all nibbles.
- A=0x8000, B=0x0001, Bin=0: Diff=0x7FFF, Bout=0. With NIBBLE_SUB_OVF_EN, ovf=1; without it, ovf=0.
- start held high while busy, with A/B changed mid-run: the result reflects the operands latched at acceptance. start=1 in the done cycle is accepted, and the second done follows 5 cycles after the first.
- rst_n pulsed low two cycles after acceptance: busy, done, Diff, Bout and ovf are 0 at once, and no done follows after release.
- Randomized check of 10k operand pairs against a behavioral A−B−Bin model, under both macro settings.
